ofmap_writeback: RTL and testbench
==================================

# ofmap_writeback

Receives the column-skewed quantized ofmap rows that the accumulator emits, deskews them into whole rows, optionally applies ReLU, buffers them, and writes them to the global buffer (GLB) at consecutive addresses. Sits between the MMU accumulator output and the GLB ofmap write port. Absorbs GLB backpressure, because the accumulator side cannot be stalled.

## Interface
- PE_SIZE, 14, number of columns per row
- DATA_WIDTH, 8, bits per ofmap element
- ADDR_WIDTH, 16, GLB word address width
- ROW_NUM, 70, rows written per job
- FIFO_DEPTH, 4, aligned-row buffer entries (power of two, ≥2)

- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle job start pulse
- base_addr_i  input  ADDR_WIDTH  first GLB address, sampled on start_i
- ofmap_row_i  input  DATA_WIDTH*PE_SIZE  skewed row data; column j at bits [DATA_WIDTH*j +: DATA_WIDTH]
- ofmap_valid_i  input  1  row-valid pulse, time-aligned to column PE_SIZE-1
- glb_wren_o  output  1  GLB write request
- glb_addr_o  output  ADDR_WIDTH  GLB write address
- glb_wdata_o  output  DATA_WIDTH*PE_SIZE  aligned row, same column packing
- glb_ready_i  input  1  GLB accepts the write this cycle
- busy_o  output  1  job in progress
- done_o  output  1  one-cycle job-complete pulse
- overflow_o  output  1  sticky flag: an aligned row was dropped

## Operation
- Skew model: for a row flagged at cycle t, column j is valid at cycle t+(PE_SIZE-1-j).
- Deskew: column j passes through j register stages; the valid flag passes through PE_SIZE-1 stages. Aligned row and aligned valid appear together at cycle t+PE_SIZE-1.
- Issue gate: ofmap_valid_i enters the valid pipeline only when state==RUN and issued_cnt<ROW_NUM. issued_cnt increments on each entry. Pulses outside this window are ignored.
- An aligned valid pushes the row into the FIFO. If the FIFO is full and no pop occurs that cycle, the row is dropped and overflow_o sets. A simultaneous push and pop on a full FIFO is accepted.
- GLB side:
  - glb_wren_o = FIFO not empty; glb_wdata_o = FIFO head.
  - A write is accepted when glb_wren_o & glb_ready_i. Acceptance pops the FIFO and increments wr_cnt.
  - glb_addr_o = base_addr + wr_cnt, modulo 2^ADDR_WIDTH (wrap permitted).
- States:
  - IDLE: on start_i, latch base_addr_i; clear issued_cnt, wr_cnt and overflow_o; go to RUN.
  - RUN: when issued_cnt==ROW_NUM, go to DRAIN.
  - DRAIN: when the valid pipeline is empty and the FIFO is empty, go to DONE.
  - DONE: assert done_o for one cycle; go to IDLE.
- start_i outside IDLE is ignored.
- busy_o = state≠IDLE.
- Dropped rows are not retried. A job always terminates; wr_cnt may end below ROW_NUM only when overflow_o=1.

## Timing
- Reset values: glb_wren_o=0, glb_addr_o=0, glb_wdata_o=0, busy_o=0, done_o=0, overflow_o=0. State=IDLE; FIFO, counters and all deskew stages cleared.
- Latency with glb_ready_i held high: ofmap_valid_i at cycle t gives glb_wren_o at cycle t+PE_SIZE, because the FIFO is written at the edge ending cycle t+PE_SIZE-1 and reads fall through.
- The start_i edge moves the state to RUN. An ofmap_valid_i in the same cycle as start_i is ignored; the first valid counted is one cycle later.
- Asserting rst mid-job discards in-flight data immediately, with no partial writes after reset.
- done_o asserts the cycle after the final write is accepted plus one cycle for the DRAIN→DONE transition.

## Configuration
- OFMAP_WRITEBACK_RELU_EN
  - Defined: each aligned element is treated as signed two's complement, and negative values are replaced by 0 before the FIFO push.
  - Undefined: elements pass unmodified.
  - Latency is identical in both cases.

## Structure
- Shared package ofmap_wb_pkg: state enum {IDLE, RUN, DRAIN, DONE} and the row-width constant DATA_WIDTH*PE_SIZE.
- One sub-module: ofmap_wb_fifo. It is a synchronous fall-through FIFO (width, depth parameters) with push, pop, full, empty and same-cycle push/pop on full.
- Deskew registers, counters and the state machine live in the top level.

## Test plan
- Basic job:
  - Stimulus: PE_SIZE=4, ROW_NUM=3, base 0x0100, ready high. Three skewed rows where column j carries row r's value 0x10*r+j.
  - Required: writes at 0x0100–0x0102 with aligned data, first glb_wren_o 4 cycles after the first valid, then done_o once.
- Backpressure:
  - Stimulus: ready low for 6 cycles, FIFO_DEPTH=4, 4 rows.
  - Required: no drop, overflow_o=0, all 4 written in order after ready rises.
- Overflow:
  - Stimulus: ready low, 6 back-to-back rows, FIFO_DEPTH=4.
  - Required: overflow_o=1, rows 0–3 written, done_o still pulses.
- Gating:
  - Stimulus: valids issued during IDLE, in the start_i cycle, and after ROW_NUM rows.
  - Required: none of them are written.
- Wrap:
  - Stimulus: base 0xFFFE, ROW_NUM=3.
  - Required: addresses 0xFFFE, 0xFFFF, 0x0000.
- ReLU and reset:
  - Stimulus: with OFMAP_WRITEBACK_RELU_EN defined, element 0x85 → 0x00 and 0x7F → 0x7F. Assert rst mid-DRAIN.
  - Required: all outputs 0 next cycle; no further writes.

Source files
------------

// File: rtl/ofmap_wb_pkg.sv
// Shared types and constants for the ofmap writeback block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   wb_state_t  job state machine encoding (IDLE, RUN, DRAIN, DONE)
//   ROW_WIDTH   packed row width for the default geometry
//   row_width() packed row width for any geometry
package ofmap_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    localparam int PE_SIZE_DEF    = 14;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ROW_WIDTH      = DATA_WIDTH_DEF * PE_SIZE_DEF;

    function automatic int row_width(input int pe_size, input int data_width);
        return pe_size * data_width;
    endfunction

endpackage

// File: rtl/ofmap_wb_fifo.sv
// Synchronous fall-through FIFO holding aligned ofmap rows.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push on full is refused unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears pointers and storage)
//   push       write push_data this cycle
//   push_data  entry to write
//   pop        consume the head entry this cycle (ignored when empty)
//   head       current head entry (combinational read)
//   full       no free entries
//   empty      no stored entries
module ofmap_wb_fifo
    import ofmap_wb_pkg::*;
#(
    parameter int WIDTH = ROW_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit separates full from empty when the indices match.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push needs, so full with pop still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[PW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofmap_writeback.sv
// Deskews accumulator ofmap rows, optionally applies ReLU, buffers and writes them to GLB.
// Latency: ofmap_valid_i at cycle t gives glb_wren_o at t+PE_SIZE when glb_ready_i is high.
// Backpressure: input cannot stall; FIFO absorbs GLB stalls, rows arriving on a full FIFO are dropped (overflow_o).
//
// Build option: define OFMAP_WRITEBACK_RELU_EN to clamp negative (signed) elements to zero before buffering.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         one-cycle job start (IDLE only); base_addr_i sampled with it
//   ofmap_row_i     skewed row, column j at [DATA_WIDTH*j +: DATA_WIDTH]
//   ofmap_valid_i   row flag aligned to column PE_SIZE-1
//   glb_wren_o      write request (FIFO not empty)
//   glb_addr_o      base + rows written so far, wrapping
//   glb_wdata_o     aligned row at FIFO head
//   glb_ready_i     GLB accepts the write this cycle
//   busy_o, done_o  job active / one-cycle completion pulse
//   overflow_o      sticky: an aligned row was dropped this job
module ofmap_writeback
    import ofmap_wb_pkg::*;
#(
    parameter int PE_SIZE    = 14,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int ROW_NUM    = 70,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    input  logic                          ofmap_valid_i,
    output logic                          glb_wren_o,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
    input  logic                          glb_ready_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);

    localparam int ROW_W = row_width(PE_SIZE, DATA_WIDTH);
    localparam int CNT_W = $clog2(ROW_NUM + 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_NUM);

    wb_state_t             state;
    wb_state_t             state_nxt;
    logic [CNT_W-1:0]      issued_cnt;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic                  overflow;
    logic [PE_SIZE-2:0]    vld_pipe;
    logic [ROW_W-1:0]      aligned_row;
    logic [ROW_W-1:0]      push_row;
    logic                  aligned_vld;
    logic                  issue;
    logic                  start_job;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_accept;
    logic                  drop;

    // ------------------------------------------------------------------
    // Issue gate: only the first ROW_NUM flags seen while running count.
    // ------------------------------------------------------------------
    assign start_job = (state == IDLE) && start_i;
    assign issue     = ofmap_valid_i && (state == RUN) && (issued_cnt < ROW_LAST);

    // ------------------------------------------------------------------
    // Deskew: column j arrives PE_SIZE-1-j cycles after the flag, so it
    // is delayed j cycles to line up with the last column.
    // ------------------------------------------------------------------
    for (genvar j = 0; j < PE_SIZE; j++) begin : g_col
        if (j == 0) begin : g_pass
            assign aligned_row[DATA_WIDTH*j +: DATA_WIDTH] = ofmap_row_i[DATA_WIDTH*j +: DATA_WIDTH];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] stg [j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < j; k++) begin
                        stg[k] <= '0;
                    end
                end else begin
                    stg[0] <= ofmap_row_i[DATA_WIDTH*j +: DATA_WIDTH];
                    for (int k = 1; k < j; k++) begin
                        stg[k] <= stg[k-1];
                    end
                end
            end
            assign aligned_row[DATA_WIDTH*j +: DATA_WIDTH] = stg[j-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue;
            for (int k = 1; k < PE_SIZE - 1; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
        end
    end

    assign aligned_vld = vld_pipe[PE_SIZE-2];

    // ------------------------------------------------------------------
    // Optional ReLU on the aligned row (combinational, no added latency).
    // ------------------------------------------------------------------
    always_comb begin
        push_row = aligned_row;
`ifdef OFMAP_WRITEBACK_RELU_EN
        for (int j = 0; j < PE_SIZE; j++) begin
            if (aligned_row[DATA_WIDTH*j + DATA_WIDTH - 1]) begin
                push_row[DATA_WIDTH*j +: DATA_WIDTH] = '0;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Row buffer and GLB write side.
    // ------------------------------------------------------------------
    ofmap_wb_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aligned_vld),
        .push_data (push_row),
        .pop       (wr_accept),
        .head      (glb_wdata_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign wr_accept  = !fifo_empty && glb_ready_i;
    // On a full FIFO the row survives only if the head leaves this cycle.
    assign drop       = aligned_vld && fifo_full && !wr_accept;
    assign glb_wren_o = !fifo_empty;
    assign glb_addr_o = base_addr + wr_cnt;
    assign overflow_o = overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_addr  <= '0;
            issued_cnt <= '0;
            wr_cnt     <= '0;
            overflow   <= 1'b0;
        end else if (start_job) begin
            base_addr  <= base_addr_i;
            issued_cnt <= '0;
            wr_cnt     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (issue) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            if (wr_accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Job state machine.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (issued_cnt == ROW_LAST) state_nxt = DRAIN;
            // Rows still in the deskew pipe will land in the FIFO, so both must be empty.
            DRAIN:   if ((vld_pipe == '0) && fifo_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
        done_o = (state == DONE);
    end

endmodule

// File: tb/tb_ofmap_writeback.sv
module tb_ofmap_writeback;

    localparam int P    = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int RW   = P * DW;
    localparam int NA   = 3;
    localparam int NB   = 6;
    localparam int FD   = 4;
    localparam int NCYC = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_a, start_b;
    logic [AW-1:0] base;
    logic [RW-1:0] row;
    logic          valid;
    logic          ready;

    logic          wren_a, busy_a, done_a, ovf_a;
    logic [AW-1:0] addr_a;
    logic [RW-1:0] wdata_a;
    logic          wren_b, busy_b, done_b, ovf_b;
    logic [AW-1:0] addr_b;
    logic [RW-1:0] wdata_b;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    logic          sv [NCYC];
    logic          sr [NCYC];
    logic [RW-1:0] sd [NCYC];

    int cyc, n_assert, n_fail;
    int wr_a, wr_b, done_cnt_a, done_cnt_b, done_cyc_a, first_a;
    int cs, snap_w, snap_d;

    ofmap_writeback #(
        .PE_SIZE(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_NUM(NA), .FIFO_DEPTH(FD)
    ) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .base_addr_i(base),
        .ofmap_row_i(row), .ofmap_valid_i(valid),
        .glb_wren_o(wren_a), .glb_addr_o(addr_a), .glb_wdata_o(wdata_a),
        .glb_ready_i(ready), .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a)
    );

    ofmap_writeback #(
        .PE_SIZE(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_NUM(NB), .FIFO_DEPTH(FD)
    ) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .base_addr_i(base),
        .ofmap_row_i(row), .ofmap_valid_i(valid),
        .glb_wren_o(wren_b), .glb_addr_o(addr_b), .glb_wdata_o(wdata_b),
        .glb_ready_i(ready), .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference row: column j of row r holds 0x10*r + j.
    function automatic logic [RW-1:0] mk_row(input int r);
        logic [RW-1:0] v;
        for (int j = 0; j < P; j++) v[DW*j +: DW] = 8'(16 * r + j);
        return v;
    endfunction

    function automatic logic [RW-1:0] relu(input logic [RW-1:0] v);
        logic [RW-1:0] o;
        o = v;
`ifdef OFMAP_WRITEBACK_RELU_EN
        for (int j = 0; j < P; j++) if (v[DW*j + DW - 1]) o[DW*j +: DW] = 8'h00;
`endif
        return o;
    endfunction

    // Place a row flagged at cycle t onto the skewed bus schedule.
    task automatic sched_row(input int t, input logic [RW-1:0] v);
        sv[t] = 1'b1;
        for (int j = 0; j < P; j++) sd[t + P - 1 - j][DW*j +: DW] = v[DW*j +: DW];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc   = cyc + 1;
        valid = sv[cyc];
        row   = sd[cyc];
        ready = sr[cyc];
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    // Scoreboard side: every accepted GLB write must match the oldest expectation.
    always @(negedge clk) begin
        if (wren_a && ready) begin
            wr_a++;
            if (first_a < 0) first_a = cyc;
            check("a_write_expected", 64'(q_a.size() != 0), 64'd1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                check("a_addr", 64'(addr_a), 64'(ea.addr));
                check("a_data", 64'(wdata_a), 64'(ea.data));
            end
        end
        if (wren_b && ready) begin
            wr_b++;
            check("b_write_expected", 64'(q_b.size() != 0), 64'd1);
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                check("b_addr", 64'(addr_b), 64'(eb.addr));
                check("b_data", 64'(wdata_b), 64'(eb.data));
            end
        end
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (done_b) done_cnt_b++;
    end

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; base = '0;
        row = '0; valid = 1'b0; ready = 1'b1;
        cyc = 0; n_assert = 0; n_fail = 0; wr_a = 0; wr_b = 0;
        done_cnt_a = 0; done_cnt_b = 0; done_cyc_a = -1; first_a = -1;
        for (int i = 0; i < NCYC; i++) begin
            sv[i] = 1'b0; sr[i] = 1'b1; sd[i] = '0;
        end

        // Reset state
        repeat (3) tick();
        check("a_reset_outputs", 64'({wren_a, addr_a, wdata_a, busy_a, done_a, ovf_a}), 64'd0);
        check("b_reset_outputs", 64'({wren_b, addr_b, wdata_b, busy_b, done_b, ovf_b}), 64'd0);
        rst = 1'b0;

        // Basic job on A, with gated flags in IDLE, in the start cycle, and past ROW_NUM
        sched_row(cyc + 2, 32'hEEEE_EEEE);
        cs = cyc + 6;
        base = 16'h0100;
        sched_row(cs, 32'hDDDD_DDDD);
        for (int r = 0; r < 3; r++) begin
            sched_row(cs + 1 + r, mk_row(r));
            q_a.push_back({16'h0100 + 16'(r), relu(mk_row(r))});
        end
        sched_row(cs + 4, 32'hCCCC_CCCC);
        sched_row(cs + 7, 32'hBBBB_BBBB);
        goto(cs); start_a = 1'b1; tick(); start_a = 1'b0;
        check("a_busy_after_start", 64'(busy_a), 64'd1);
        goto(cs + 20);
        check("a_first_write_latency", 64'(first_a), 64'(cs + 5));
        check("a_done_cycle", 64'(done_cyc_a), 64'(cs + 9));
        check("a_done_count", 64'(done_cnt_a), 64'd1);
        check("a_basic_writes", 64'(wr_a), 64'd3);
        check("a_basic_queue_empty", 64'(q_a.size()), 64'd0);
        check("a_basic_ovf", 64'(ovf_a), 64'd0);
        check("a_idle_busy", 64'(busy_a), 64'd0);
        check("b_untouched_writes", 64'(wr_b), 64'd0);

        // Address wrap on A
        cs = cyc + 2;
        base = 16'hFFFE;
        for (int r = 0; r < 3; r++) begin
            sched_row(cs + 1 + r, mk_row(r + 3));
            q_a.push_back({16'hFFFE + 16'(r), relu(mk_row(r + 3))});
        end
        goto(cs); start_a = 1'b1; tick(); start_a = 1'b0;
        goto(cs + 20);
        check("a_wrap_writes", 64'(wr_a), 64'd6);
        check("a_wrap_done", 64'(done_cnt_a), 64'd2);
        check("a_wrap_queue_empty", 64'(q_a.size()), 64'd0);

        // Backpressure on B: ready low 6 cycles while 4 rows fill the FIFO
        cs = cyc + 2;
        base = 16'h0200;
        snap_w = wr_b; snap_d = done_cnt_b;
        for (int r = 0; r < 6; r++) begin
            sched_row((r < 4) ? cs + 1 + r : cs + 8 + r, mk_row(r + 1));
            q_b.push_back({16'h0200 + 16'(r), relu(mk_row(r + 1))});
        end
        for (int c = cs + 3; c <= cs + 8; c++) sr[c] = 1'b0;
        goto(cs); start_b = 1'b1; tick(); start_b = 1'b0;
        goto(cs + 9);
        check("b_bp_no_write_while_stalled", 64'(wr_b - snap_w), 64'd0);
        check("b_bp_fifo_holding", 64'(wren_b), 64'd1);
        goto(cs + 30);
        check("b_bp_writes", 64'(wr_b - snap_w), 64'd6);
        check("b_bp_ovf", 64'(ovf_b), 64'd0);
        check("b_bp_done", 64'(done_cnt_b - snap_d), 64'd1);
        check("b_bp_queue_empty", 64'(q_b.size()), 64'd0);

        // Overflow on B: 6 back-to-back rows, ready low, only rows 0-3 survive
        cs = cyc + 2;
        base = 16'h0300;
        snap_w = wr_b; snap_d = done_cnt_b;
        for (int r = 0; r < 6; r++) begin
            sched_row(cs + 1 + r, mk_row(r + 7));
            if (r < 4) q_b.push_back({16'h0300 + 16'(r), relu(mk_row(r + 7))});
        end
        for (int c = cs; c <= cs + 14; c++) sr[c] = 1'b0;
        goto(cs); start_b = 1'b1; tick(); start_b = 1'b0;
        goto(cs + 10);
        check("b_ovf_set", 64'(ovf_b), 64'd1);
        goto(cs + 30);
        check("b_ovf_sticky", 64'(ovf_b), 64'd1);
        check("b_ovf_writes", 64'(wr_b - snap_w), 64'd4);
        check("b_ovf_done", 64'(done_cnt_b - snap_d), 64'd1);
        check("b_ovf_queue_empty", 64'(q_b.size()), 64'd0);
        check("b_ovf_idle", 64'(busy_b), 64'd0);

        // Push and pop together on a full FIFO: no drop
        cs = cyc + 2;
        base = 16'h0400;
        snap_w = wr_b; snap_d = done_cnt_b;
        for (int r = 0; r < 6; r++) begin
            sched_row(cs + 1 + r, mk_row(r + 2));
            q_b.push_back({16'h0400 + 16'(r), relu(mk_row(r + 2))});
        end
        for (int c = cs; c <= cs + 7; c++) sr[c] = 1'b0;
        goto(cs); start_b = 1'b1; tick(); start_b = 1'b0;
        check("b_ovf_cleared_on_start", 64'(ovf_b), 64'd0);
        goto(cs + 30);
        check("b_full_pushpop_ovf", 64'(ovf_b), 64'd0);
        check("b_full_pushpop_writes", 64'(wr_b - snap_w), 64'd6);
        check("b_full_pushpop_done", 64'(done_cnt_b - snap_d), 64'd1);
        check("b_full_pushpop_queue_empty", 64'(q_b.size()), 64'd0);

        // Signed elements on A (0x85/0x80/0xFF clamp when ReLU is built in)
        cs = cyc + 2;
        base = 16'h0500;
        snap_w = wr_a;
        sched_row(cs + 1, 32'h857F_0180);
        sched_row(cs + 2, 32'h7F85_FF00);
        sched_row(cs + 3, 32'h0102_7F85);
        q_a.push_back({16'h0500, relu(32'h857F_0180)});
        q_a.push_back({16'h0501, relu(32'h7F85_FF00)});
        q_a.push_back({16'h0502, relu(32'h0102_7F85)});
        goto(cs); start_a = 1'b1; tick(); start_a = 1'b0;
        goto(cs + 20);
        check("a_relu_writes", 64'(wr_a - snap_w), 64'd3);
        check("a_relu_queue_empty", 64'(q_a.size()), 64'd0);

        // Reset in DRAIN with rows still buffered: nothing may be written afterwards
        cs = cyc + 2;
        base = 16'h0600;
        snap_w = wr_a; snap_d = done_cnt_a;
        for (int r = 0; r < 3; r++) sched_row(cs + 1 + r, mk_row(r + 1));
        for (int c = cs; c <= cs + 10; c++) sr[c] = 1'b0;
        goto(cs); start_a = 1'b1; tick(); start_a = 1'b0;
        goto(cs + 7);
        check("a_pre_reset_busy", 64'(busy_a), 64'd1);
        check("a_pre_reset_wren", 64'(wren_a), 64'd1);
        rst = 1'b1;
        tick();
        check("a_mid_reset_outputs", 64'({wren_a, addr_a, wdata_a, busy_a, done_a, ovf_a}), 64'd0);
        check("b_mid_reset_outputs", 64'({wren_b, addr_b, wdata_b, busy_b, done_b, ovf_b}), 64'd0);
        rst = 1'b0;
        goto(cs + 40);
        check("a_post_reset_writes", 64'(wr_a - snap_w), 64'd0);
        check("a_post_reset_done", 64'(done_cnt_a - snap_d), 64'd0);
        check("a_post_reset_busy", 64'(busy_a), 64'd0);
        check("a_final_queue_empty", 64'(q_a.size()), 64'd0);
        check("b_final_queue_empty", 64'(q_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
